// File: rtl/clk_div_bank_if.sv
// Configuration port of the clock divider bank: a valid/ready request that carries
// the target channel, the new divisor and the output mode.
interface clk_div_bank_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 24
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_mode, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_mode, output cfg_ready);
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel clock/tick generator. Each channel divides CLK100MHz by a divisor
// that can be reprogrammed at runtime and swapped in only on a period boundary.
module clk_div_bank #(
  parameter int                      NUM_CH   = 3,
  parameter int                      CNT_W    = 24,
  parameter int                      CH_W     = 2,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIVS = {24'd262144, 24'd100000, 24'd2048}
) (
  input  logic              CLK100MHz,
  input  logic              RESETn,
  clk_div_bank_if.slave     cfg,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_all,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              pend_valid_q, pend_valid_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0]  pend_div_q, pend_div_d;
  logic              pend_mode_q, pend_mode_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] apply;

  // A pending request lands on its channel only where a period ends anyway,
  // or right away when the channel is idle or being realigned.
  always_comb begin
    wrap  = '0;
    apply = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]  = (cnt_q[i] == div_q[i] - CNT_W'(1));
      apply[i] = pend_valid_q && (int'(pend_ch_q) == i) &&
                 (sync_all || !ch_en[i] || wrap[i]);
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    div_d        = div_q;
    mode_d       = mode_q;
    clk_out_d    = clk_out_q;
    tick_d       = tick_q;
    pend_ch_d    = pend_ch_q;
    pend_div_d   = pend_div_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q && !(|apply);

    for (int i = 0; i < NUM_CH; i++) begin
      if (apply[i]) begin
        div_d[i]  = pend_div_q;
        mode_d[i] = pend_mode_q;
      end
      if (!ch_en[i] || sync_all) begin
        cnt_d[i]     = '0;
        tick_d[i]    = 1'b0;
        clk_out_d[i] = 1'b0;
      end else begin
        cnt_d[i]     = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
        tick_d[i]    = wrap[i];
        clk_out_d[i] = mode_d[i] ? wrap[i] : (cnt_d[i] >= (div_d[i] >> 1));
      end
    end

    // Requests for channels that do not exist are accepted and dropped.
    if (cfg.cfg_valid && cfg_ready_q && (int'(cfg.cfg_ch) < NUM_CH)) begin
      pend_valid_d = 1'b1;
      pend_ch_d    = cfg.cfg_ch;
      pend_div_d   = (cfg.cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg.cfg_div;
      pend_mode_d  = cfg.cfg_mode;
    end
    cfg_ready_d = !pend_valid_d;
  end

  always_ff @(posedge CLK100MHz or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DEF_DIVS[i*CNT_W +: CNT_W];
      end
      mode_q       <= '0;
      clk_out_q    <= '0;
      tick_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      pend_mode_q  <= 1'b0;
      cfg_ready_q  <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      mode_q       <= mode_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      pend_valid_q <= pend_valid_d;
      pend_ch_q    <= pend_ch_d;
      pend_div_q   <= pend_div_d;
      pend_mode_q  <= pend_mode_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  assign clk_out       = clk_out_q;
  assign tick          = tick_q;
  assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: a phase-arithmetic model checked every cycle, plus
// directed scenarios with hand-computed periods, duty cycles and handshake levels.
module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 24;
  localparam int CH_W   = 2;

  logic              CLK100MHz = 1'b0;
  logic              RESETn;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_all;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  clk_div_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg ();

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .CLK100MHz (CLK100MHz),
    .RESETn    (RESETn),
    .cfg       (cfg.slave),
    .ch_en     (ch_en),
    .sync_all  (sync_all),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 CLK100MHz = ~CLK100MHz;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Model: each channel's phase is (edge index - origin) mod divisor, where origin is
  // the last edge at which the channel was held idle, realigned or given a new divisor.
  int unsigned def_div [NUM_CH] = '{2048, 100000, 262144};
  int unsigned m_div    [NUM_CH];
  bit          m_mode   [NUM_CH];
  longint      m_origin [NUM_CH];
  longint      k = 0;
  bit          p_valid = 1'b0;
  int          p_ch;
  int unsigned p_div;
  bit          p_mode;
  bit [NUM_CH-1:0] exp_clk   = '0;
  bit [NUM_CH-1:0] exp_tick  = '0;
  bit              exp_ready = 1'b1;

  always @(posedge CLK100MHz) begin
    bit xfer;
    bit applied;
    bit w;
    longint ph;
    k++;
    if (!RESETn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i] = def_div[i];
        m_mode[i] = 1'b0;
        m_origin[i] = k;
      end
      p_valid = 1'b0;
      exp_clk = '0;
      exp_tick = '0;
      exp_ready = 1'b1;
    end else begin
      xfer = cfg.cfg_valid && exp_ready;
      applied = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_en[i] || sync_all) begin
          if (p_valid && p_ch == i) begin
            m_div[i] = p_div;
            m_mode[i] = p_mode;
            applied = 1'b1;
          end
          m_origin[i] = k;
          exp_tick[i] = 1'b0;
          exp_clk[i] = 1'b0;
        end else begin
          w = (k > m_origin[i]) && (((k - m_origin[i]) % longint'(m_div[i])) == 0);
          if (w && p_valid && p_ch == i) begin
            m_div[i] = p_div;
            m_mode[i] = p_mode;
            m_origin[i] = k;
            applied = 1'b1;
          end
          ph = (k - m_origin[i]) % longint'(m_div[i]);
          exp_tick[i] = w;
          exp_clk[i] = m_mode[i] ? w : (ph >= longint'(m_div[i] / 2));
        end
      end
      if (applied) p_valid = 1'b0;
      if (xfer && int'(cfg.cfg_ch) < NUM_CH) begin
        p_valid = 1'b1;
        p_ch = int'(cfg.cfg_ch);
        p_div = (int'(cfg.cfg_div) < 2) ? 2 : int'(cfg.cfg_div);
        p_mode = cfg.cfg_mode;
      end
      exp_ready = !p_valid;
    end
  end

  always @(negedge CLK100MHz) begin
    if (RESETn === 1'b1)
      check_output("cycle {clk_out,tick,cfg_ready}", {25'd0, clk_out, tick, cfg.cfg_ready},
                   {25'd0, exp_clk, exp_tick, exp_ready});
  end

  task automatic apply_stimulus(input int ch, input int div, input bit mode);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = CH_W'(ch);
    cfg.cfg_div   = CNT_W'(div);
    cfg.cfg_mode  = mode;
    @(negedge CLK100MHz);
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      @(negedge CLK100MHz);
      n++;
    end while (tick[ch] !== 1'b1 && n < limit);
    if (tick[ch] !== 1'b1) n = -1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int hi;
    RESETn = 1'b0;
    ch_en = '0;
    sync_all = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch = '0;
    cfg.cfg_div = '0;
    cfg.cfg_mode = 1'b0;
    repeat (3) @(negedge CLK100MHz);
    check_output("reset cfg_ready", {31'd0, cfg.cfg_ready}, 32'd1);
    check_output("reset clk_out", {29'd0, clk_out}, 32'd0);
    check_output("reset tick", {29'd0, tick}, 32'd0);

    $display("[TB] defaults, all channels enabled");
    RESETn = 1'b1;
    ch_en = 3'b111;
    wait_tick(0, 3000, n);
    check_output("t1 first tick latency", n, 32'd2048);
    wait_tick(0, 3000, n);
    check_output("t1 ch0 period", n, 32'd2048);
    hi = 0;
    for (int j = 0; j < 2048; j++) begin
      @(negedge CLK100MHz);
      hi += int'(clk_out[0]);
    end
    check_output("t1 ch0 high cycles", hi, 32'd1024);

    $display("[TB] channel 0 disable and re-enable");
    repeat (1100) @(negedge CLK100MHz);
    check_output("t5 clk_out high before drop", {31'd0, clk_out[0]}, 32'd1);
    ch_en = 3'b110;
    @(negedge CLK100MHz);
    check_output("t5 outputs cleared", {30'd0, clk_out[0], tick[0]}, 32'd0);
    repeat (19) @(negedge CLK100MHz);
    ch_en = 3'b111;
    wait_tick(0, 3000, n);
    check_output("t5 tick after re-enable", n, 32'd2048);

    $display("[TB] reprogram ch0 mid-period");
    repeat (500) @(negedge CLK100MHz);
    apply_stimulus(0, 10, 1'b0);
    check_output("t2 cfg_ready low", {31'd0, cfg.cfg_ready}, 32'd0);
    wait_tick(0, 3000, n);
    check_output("t2 old period completes", n, 32'd1547);
    check_output("t2 cfg_ready back", {31'd0, cfg.cfg_ready}, 32'd1);
    wait_tick(0, 100, n);
    check_output("t2 new period", n, 32'd10);

    $display("[TB] divisor clamp and odd divisor on ch1");
    ch_en = 3'b101;
    apply_stimulus(1, 1, 1'b0);
    @(negedge CLK100MHz);
    check_output("t3 cfg_ready after idle apply", {31'd0, cfg.cfg_ready}, 32'd1);
    ch_en = 3'b111;
    for (int j = 0; j < 6; j++) begin
      @(negedge CLK100MHz);
      check_output("t3 div2 toggle", {31'd0, clk_out[1]}, (j % 2 == 0) ? 32'd1 : 32'd0);
    end
    apply_stimulus(1, 7, 1'b0);
    wait_tick(1, 20, n);
    hi = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge CLK100MHz);
      hi += int'(clk_out[1]);
    end
    check_output("t3 div7 high cycles", hi, 32'd4);
    wait_tick(1, 20, n);
    check_output("t3 div7 period", n, 32'd7);

    $display("[TB] pulse mode on ch2 applied by sync_all");
    apply_stimulus(2, 5, 1'b1);
    sync_all = 1'b1;
    @(negedge CLK100MHz);
    sync_all = 1'b0;
    check_output("t4 cfg_ready after sync apply", {31'd0, cfg.cfg_ready}, 32'd1);
    check_output("t4 no tick on sync", {29'd0, tick}, 32'd0);
    wait_tick(2, 20, n);
    check_output("t4 first pulse", n, 32'd5);
    check_output("t4 clk_out mirrors tick", {31'd0, clk_out[2]}, 32'd1);
    hi = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK100MHz);
      hi += int'(clk_out[2]);
    end
    check_output("t4 pulses in 10 cycles", hi, 32'd2);

    $display("[TB] sync_all on a wrap edge with a simultaneous request");
    wait_tick(0, 100, n);
    repeat (9) @(negedge CLK100MHz);
    sync_all = 1'b1;
    apply_stimulus(0, 12, 1'b0);
    sync_all = 1'b0;
    check_output("t6 sync suppresses tick", {31'd0, tick[0]}, 32'd0);
    check_output("t6 request still pending", {31'd0, cfg.cfg_ready}, 32'd0);
    wait_tick(0, 100, n);
    check_output("t6 old divisor after sync", n, 32'd10);
    wait_tick(0, 100, n);
    check_output("t6 new divisor", n, 32'd12);

    $display("[TB] reset with a pending request");
    apply_stimulus(0, 1000, 1'b0);
    #3 RESETn = 1'b0;
    #1;
    check_output("t6 reset cfg_ready", {31'd0, cfg.cfg_ready}, 32'd1);
    check_output("t6 reset outputs", {26'd0, clk_out, tick}, 32'd0);
    repeat (2) @(negedge CLK100MHz);
    RESETn = 1'b1;
    wait_tick(0, 3000, n);
    check_output("t6 default divisor restored", n, 32'd2048);
    repeat (5) @(negedge CLK100MHz);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
